// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC generator for the MIPS core.
// It computes the sequential PC every cycle. A taken branch or jump redirects
// fetch with one delay slot: the delay-slot PC is issued first, and the target
// follows on the next cycle.
// Optional feature macro: PC_EXC_EN. When defined, it adds exc_i and epc_o.
// An exception forces a redirect to EXC_VEC and captures the faulting PC.
module pc_next_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     PC_STEP   = 1
`ifdef PC_EXC_EN
  ,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(16'h0080)
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_value_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
`ifdef PC_EXC_EN
  input  logic            exc_i,
  output logic [PC_W-1:0] epc_o,
`endif
  output logic [PC_W-1:0] pc_new_value_o,
  output logic            delay_slot_o,
  output logic            redirect_o,
  output logic            err_o
);

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ds_q, ds_d;
  logic            redir_q, redir_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] sum;
  logic            req;
  logic [PC_W-1:0] sel_tgt;
`ifdef PC_EXC_EN
  logic [PC_W-1:0] epc_q, epc_d;
`endif

  // Sequential address (wraps at PC_W bits) and request/target selection.
  // A jump takes priority over a branch.
  always_comb begin
    sum     = pc_value_i + PC_W'(PC_STEP);
    req     = jump_i | branch_taken_i;
    sel_tgt = jump_i ? jump_target_i : branch_target_i;
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pc_d       = pc_q;
    ds_d       = ds_q;
    redir_d    = redir_q;
    err_d      = err_q;
`ifdef PC_EXC_EN
    epc_d      = epc_q;
`endif
    if (!stall_i) begin
      unique case (state_q)
        SEQ: begin
          pc_d    = sum;
          redir_d = 1'b0;
          if (req) begin
            pend_tgt_d = sel_tgt;
            ds_d       = 1'b1;
            state_d    = SLOT;
          end else begin
            ds_d = 1'b0;
          end
        end
        SLOT: begin
          // A branch or jump issued from the delay slot is dropped and flagged.
          pc_d    = pend_tgt_q;
          redir_d = 1'b1;
          ds_d    = 1'b0;
          state_d = SEQ;
          if (req) err_d = 1'b1;
        end
        default: state_d = SEQ;
      endcase
    end
`ifdef PC_EXC_EN
    // An exception overrides stall and any pending redirect.
    if (exc_i) begin
      pc_d       = EXC_VEC;
      epc_d      = pc_value_i;
      redir_d    = 1'b1;
      ds_d       = 1'b0;
      state_d    = SEQ;
      pend_tgt_d = '0;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEQ;
      pend_tgt_q <= '0;
      pc_q       <= RESET_VEC;
      ds_q       <= 1'b0;
      redir_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PC_EXC_EN
      epc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      pc_q       <= pc_d;
      ds_q       <= ds_d;
      redir_q    <= redir_d;
      err_q      <= err_d;
`ifdef PC_EXC_EN
      epc_q      <= epc_d;
`endif
    end
  end

  assign pc_new_value_o = pc_q;
  assign delay_slot_o   = ds_q;
  assign redirect_o     = redir_q;
  assign err_o          = err_q;
`ifdef PC_EXC_EN
  assign epc_o          = epc_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed testbench for pc_next_unit. Expected values are hand-computed.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_value;
  logic        stall;
  logic        br;
  logic [15:0] br_tgt;
  logic        jmp;
  logic [15:0] jmp_tgt;
  logic [15:0] pc_new;
  logic        ds;
  logic        rd;
  logic        err;
`ifdef PC_EXC_EN
  logic        exc;
  logic [15:0] epc;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pc_next_unit #(
    .PC_W     (16),
    .RESET_VEC(16'h0000),
    .PC_STEP  (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_value_i     (pc_value),
    .stall_i        (stall),
    .branch_taken_i (br),
    .branch_target_i(br_tgt),
    .jump_i         (jmp),
    .jump_target_i  (jmp_tgt),
`ifdef PC_EXC_EN
    .exc_i          (exc),
    .epc_o          (epc),
`endif
    .pc_new_value_o (pc_new),
    .delay_slot_o   (ds),
    .redirect_o     (rd),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one clock edge, then sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the PC, delay-slot and redirect outputs together.
  task automatic expect3(input string tag, input logic [15:0] p, input logic d, input logic r);
    check({tag, ".pc"}, {16'h0, pc_new}, {16'h0, p});
    check({tag, ".ds"}, {31'h0, ds}, {31'h0, d});
    check({tag, ".rd"}, {31'h0, rd}, {31'h0, r});
  endtask

  initial begin
    rst = 1'b1; pc_value = 16'h0; stall = 1'b0;
    br = 1'b0; br_tgt = 16'h0; jmp = 1'b0; jmp_tgt = 16'h0;
`ifdef PC_EXC_EN
    exc = 1'b0;
`endif
    #2;
    // Reset held for two edges.
    step(); step();
    expect3("reset", 16'h0000, 1'b0, 1'b0);
    check("reset.err", {31'h0, err}, 32'h0);
    rst = 1'b0;

    // Sequential stepping with the PC fed back.
    for (int unsigned i = 1; i <= 3; i++) begin
      pc_value = pc_new;
      step();
      expect3("seq", 16'(i), 1'b0, 1'b0);
    end

    // Branch with a delay slot.
    pc_value = 16'h0010; br = 1'b1; br_tgt = 16'h0040;
    step(); expect3("br.slot", 16'h0011, 1'b1, 1'b0);
    br = 1'b0; pc_value = 16'h0011; br_tgt = 16'h0999;
    step(); expect3("br.tgt", 16'h0040, 1'b0, 1'b1);
    pc_value = 16'h0040;
    step(); expect3("br.after", 16'h0041, 1'b0, 1'b0);

    // Stall while in the delay slot; the branch request is ignored during the stall.
    pc_value = 16'h0020; jmp = 1'b1; jmp_tgt = 16'h1234;
    step(); expect3("jmp.slot", 16'h0021, 1'b1, 1'b0);
    jmp = 1'b0; stall = 1'b1; br = 1'b1; br_tgt = 16'h0777;
    for (int unsigned i = 0; i < 3; i++) begin
      step(); expect3("stall.slot", 16'h0021, 1'b1, 1'b0);
    end
    check("stall.err", {31'h0, err}, 32'h0);
    br = 1'b0; stall = 1'b0; pc_value = 16'h0021;
    step(); expect3("jmp.tgt", 16'h1234, 1'b0, 1'b1);
    // The redirect pulse is held during a stall.
    stall = 1'b1; pc_value = 16'h1234;
    step(); expect3("stall.rd", 16'h1234, 1'b0, 1'b1);
    stall = 1'b0;
    step(); expect3("jmp.after", 16'h1235, 1'b0, 1'b0);

    // Sequential wrap at the top of the address space.
    pc_value = 16'hFFFF;
    step(); expect3("wrap", 16'h0000, 1'b0, 1'b0);

    // A jump takes priority over a branch.
    pc_value = 16'h0000; jmp = 1'b1; jmp_tgt = 16'h0100; br = 1'b1; br_tgt = 16'h0200;
    step(); expect3("prio.slot", 16'h0001, 1'b1, 1'b0);
    jmp = 1'b0; br = 1'b0; pc_value = 16'h0001;
    step(); expect3("prio.tgt", 16'h0100, 1'b0, 1'b1);

    // An illegal request in the delay slot is dropped and err_o sticks.
    pc_value = 16'h0050; br = 1'b1; br_tgt = 16'h0060;
    step(); expect3("ill.slot", 16'h0051, 1'b1, 1'b0);
    check("ill.err0", {31'h0, err}, 32'h0);
    pc_value = 16'h0051; br_tgt = 16'h0070;
    step(); expect3("ill.tgt", 16'h0060, 1'b0, 1'b1);
    check("ill.err1", {31'h0, err}, 32'h1);
    br = 1'b0; pc_value = 16'h0060;
    step(); expect3("ill.after", 16'h0061, 1'b0, 1'b0);
    check("ill.sticky", {31'h0, err}, 32'h1);

    // Reset during a redirect discards the pending target and clears err_o.
    pc_value = 16'h0080; br = 1'b1; br_tgt = 16'h0300;
    step(); expect3("rst.slot", 16'h0081, 1'b1, 1'b0);
    br = 1'b0; rst = 1'b1;
    step(); expect3("rst.mid", 16'h0000, 1'b0, 1'b0);
    check("rst.err", {31'h0, err}, 32'h0);
    rst = 1'b0; pc_value = 16'h0000;
    step(); expect3("rst.after", 16'h0001, 1'b0, 1'b0);

`ifdef PC_EXC_EN
    // An exception in the slot overrides the stall and the pending jump.
    pc_value = 16'h0010; jmp = 1'b1; jmp_tgt = 16'h0200;
    step(); expect3("exc.slot", 16'h0011, 1'b1, 1'b0);
    jmp = 1'b0; stall = 1'b1; exc = 1'b1; pc_value = 16'h0033;
    step(); expect3("exc.vec", 16'h0080, 1'b0, 1'b1);
    check("exc.epc", {16'h0, epc}, 32'h0033);
    exc = 1'b0; stall = 1'b0; pc_value = 16'h0080;
    step(); expect3("exc.after", 16'h0081, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
